// File: rtl/feature_frame_assembler_pkg.sv
// Shared constants, sizing macro and state type for the feature frame assembler.
// Provides `TOTAL_NUM_CHANNEL, `CHANNEL_WIDTH and `ceilLog2 to every file that follows it.
`ifndef FEATURE_FRAME_ASSEMBLER_DEFS
`define FEATURE_FRAME_ASSEMBLER_DEFS
`define TOTAL_NUM_CHANNEL 214
`define CHANNEL_WIDTH 2
`define ceilLog2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package feature_frame_assembler_pkg;

    localparam int TOTAL_CHANNELS = `TOTAL_NUM_CHANNEL;
    localparam int FEATURE_W      = `CHANNEL_WIDTH;
    localparam int CH_IDX_W       = `ceilLog2(`TOTAL_NUM_CHANNEL);

    typedef enum logic {
        FILL    = 1'b0,
        DISCARD = 1'b1
    } asm_state_t;

    // Channel 0 lands at the MSBs, so beat k occupies the slice ending here.
    function automatic int beat_msb(input int k, input int nc, input int cw);
        return (nc - k) * cw - 1;
    endfunction

endpackage

// File: rtl/feature_frame_assembler_pingpong_buffer.sv
// Two frame registers filled one beat at a time; rd_sel picks the frame presented downstream.
module frame_pingpong_buffer
    import feature_frame_assembler_pkg::*;
#(
    parameter int NUM_CHANNEL   = TOTAL_CHANNELS,
    parameter int CHANNEL_WIDTH = FEATURE_W,
    parameter int IDX_W         = CH_IDX_W
) (
    input  logic                                 clk,
    input  logic                                 wr_en,
    input  logic                                 wr_sel,
    input  logic [IDX_W-1:0]                     wr_idx,
    input  logic [CHANNEL_WIDTH-1:0]             wr_data,
    input  logic                                 rd_sel,
    output logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] rd_data
);

    localparam int FRAME_W = NUM_CHANNEL * CHANNEL_WIDTH;

    logic [FRAME_W-1:0] bank0;
    logic [FRAME_W-1:0] bank1;

    // Contents are deliberately left unreset; occupancy in the top decides validity.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CHANNEL; k++) begin
            if (wr_en && (wr_idx == IDX_W'(k))) begin
                if (wr_sel) begin
                    bank1[beat_msb(k, NUM_CHANNEL, CHANNEL_WIDTH) -: CHANNEL_WIDTH] <= wr_data;
                end else begin
                    bank0[beat_msb(k, NUM_CHANNEL, CHANNEL_WIDTH) -: CHANNEL_WIDTH] <= wr_data;
                end
            end
        end
    end

    assign rd_data = rd_sel ? bank1 : bank0;

endmodule

// File: rtl/feature_frame_assembler.sv
// Serial feature stream to full-frame assembler with ping-pong buffering.
// Optional framing check on s_last is enabled by defining FRAME_CHECK_EN.
module feature_frame_assembler
    import feature_frame_assembler_pkg::*;
#(
    parameter int NUM_CHANNEL   = `TOTAL_NUM_CHANNEL,
    parameter int CHANNEL_WIDTH = `CHANNEL_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [CHANNEL_WIDTH-1:0]             s_feature,
    input  logic                                 s_last,
    output logic                                 fin_valid,
    input  logic                                 fin_ready,
    output logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
    output logic                                 frame_err
);

    localparam int IDX_W = `ceilLog2(NUM_CHANNEL);

    asm_state_t       state;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_sel;
    logic             rd_sel;
    logic [1:0]       occ;
    logic [1:0]       occ_next;

    logic accept;
    logic fill_beat;
    logic at_last_idx;
    logic early_last;
    logic missing_last;
    logic frame_done;
    logic frame_hs;
    logic beat_err;

    assign accept      = s_valid && s_ready;
    assign fill_beat   = accept && (state == FILL);
    assign at_last_idx = (wr_idx == IDX_W'(NUM_CHANNEL - 1));
    assign frame_hs    = fin_valid && fin_ready;

`ifdef FRAME_CHECK_EN
    assign early_last   = fill_beat && s_last && !at_last_idx;
    assign missing_last = fill_beat && !s_last && at_last_idx;
    assign frame_done   = fill_beat && s_last && at_last_idx;
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign early_last    = 1'b0;
    assign missing_last  = 1'b0;
    assign frame_done    = fill_beat && at_last_idx;
`endif

    assign beat_err = early_last || missing_last;

    // Completion and handshake in the same cycle cancel out.
    always_comb begin
        occ_next = occ;
        case ({frame_done, frame_hs})
            2'b10:   occ_next = occ + 2'd1;
            2'b01:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            wr_idx    <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            occ       <= 2'd0;
            s_ready   <= 1'b0;
            fin_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            occ       <= occ_next;
            fin_valid <= (occ_next != 2'd0);
            s_ready   <= (occ_next != 2'd2);
            frame_err <= beat_err;

            if (frame_done) begin
                wr_sel <= ~wr_sel;
            end
            if (frame_hs) begin
                rd_sel <= ~rd_sel;
            end

            case (state)
                FILL: begin
                    if (fill_beat) begin
                        wr_idx <= (at_last_idx || early_last) ? '0 : wr_idx + 1'b1;
                    end
                    if (missing_last) begin
                        state <= DISCARD;
                    end
                end
                // wr_idx was already cleared on the beat that entered this state.
                DISCARD: begin
`ifdef FRAME_CHECK_EN
                    if (accept && s_last) begin
                        state <= FILL;
                    end
`else
                    state <= FILL;
`endif
                end
            endcase
        end
    end

    frame_pingpong_buffer #(
        .NUM_CHANNEL   (NUM_CHANNEL),
        .CHANNEL_WIDTH (CHANNEL_WIDTH),
        .IDX_W         (IDX_W)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (fill_beat),
        .wr_sel  (wr_sel),
        .wr_idx  (wr_idx),
        .wr_data (s_feature),
        .rd_sel  (rd_sel),
        .rd_data (features_top)
    );

endmodule

// File: tb/tb_feature_frame_assembler.sv
// Bench for feature_frame_assembler: directed scenarios with random features and gaps,
// checked every cycle against a queue-based frame model.
module tb_feature_frame_assembler;

    localparam int NC = 214;
    localparam int CW = 2;
    localparam int FW = NC * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [CW-1:0] s_feature = '0;
    logic          s_last = 1'b0;
    logic          fin_valid;
    logic          fin_ready = 1'b0;
    logic [FW-1:0] features_top;
    logic          frame_err;

    int compared   = 0;
    int mismatched = 0;
    int cycles     = 0;

    logic          rst_req       = 1'b1;
    logic          fin_ready_req = 1'b0;
    bit            rand_ready    = 1'b0;
    bit            check_en;

    logic [CW-1:0] partial_q[$];
    logic [FW-1:0] frame_q[$];
    bit            discard_m;
    bit            ready_m;
    bit            valid_m;
    bit            err_m;
    bit            accepted_m;

    feature_frame_assembler #(
        .NUM_CHANNEL   (NC),
        .CHANNEL_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_feature    (s_feature),
        .s_last       (s_last),
        .fin_valid    (fin_valid),
        .fin_ready    (fin_ready),
        .features_top (features_top),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [FW-1:0] observed,
                               input logic [FW-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [FW-1:0] packFrame();
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < NC; k++) begin
            f[(NC - k) * CW - 1 -: CW] = partial_q[k];
        end
        return f;
    endfunction

    // Reference behaviour applied at each rising edge from the inputs that edge sampled.
    task automatic modelEdge();
        accepted_m = 1'b0;
        if (rst) begin
            partial_q.delete();
            frame_q.delete();
            discard_m = 1'b0;
            ready_m   = 1'b0;
            valid_m   = 1'b0;
            err_m     = 1'b0;
            return;
        end
        err_m = 1'b0;
        if (valid_m && fin_ready) begin
            void'(frame_q.pop_front());
        end
        if (s_valid && ready_m) begin
            accepted_m = 1'b1;
            if (discard_m) begin
                if (s_last) discard_m = 1'b0;
            end else begin
                partial_q.push_back(s_feature);
                if (partial_q.size() == NC) begin
                    if (s_last || !check_en) begin
                        frame_q.push_back(packFrame());
                    end else begin
                        err_m     = 1'b1;
                        discard_m = 1'b1;
                    end
                    partial_q.delete();
                end else if (s_last && check_en) begin
                    err_m = 1'b1;
                    partial_q.delete();
                end
            end
        end
        valid_m = (frame_q.size() != 0);
        ready_m = (frame_q.size() < 2);
    endtask

    task automatic applyStimulus(input logic v, input logic [CW-1:0] feat, input logic last);
        @(negedge clk);
        checkOutput("s_ready", FW'(s_ready), FW'(ready_m));
        checkOutput("fin_valid", FW'(fin_valid), FW'(valid_m));
        checkOutput("frame_err", FW'(frame_err), FW'(err_m));
        if (valid_m) begin
            checkOutput("features_top", features_top, frame_q[0]);
        end
        rst       = rst_req;
        fin_ready = rand_ready ? logic'($urandom_range(0, 1)) : fin_ready_req;
        s_valid   = v;
        s_feature = feat;
        s_last    = last;
        @(posedge clk);
        cycles++;
        modelEdge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, CW'($urandom), 1'b0);
        end
    endtask

    task automatic sendBeat(input logic [CW-1:0] feat, input logic last, input bit gaps);
        int budget;
        budget = 2000;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            applyStimulus(1'b0, CW'($urandom), 1'b0);
        end
        do begin
            applyStimulus(1'b1, feat, last);
            budget--;
        end while (!accepted_m && (budget > 0));
        checkOutput("beat_accept", FW'(accepted_m), FW'(1'b1));
    endtask

    task automatic sendFrame(input int len, input int last_at, input bit gaps, input bit pattern);
        for (int k = 0; k < len; k++) begin
            sendBeat(pattern ? CW'(k % 4) : CW'($urandom), (k == last_at), gaps);
        end
    endtask

    initial begin
`ifdef FRAME_CHECK_EN
        check_en = 1'b1;
`else
        check_en = 1'b0;
`endif
        @(posedge clk);
        modelEdge();

        // Reset state, then release
        idle(3);
        rst_req = 1'b0;
        idle(2);

        // Single frame with k mod 4 pattern, held by fin_ready=0
        sendFrame(NC, NC - 1, 1'b0, 1'b1);
        #2;
        checkOutput("fin_valid_after_last", FW'(fin_valid), FW'(1'b1));
        checkOutput("ch0_msb", FW'(features_top[FW-1 -: CW]), FW'(2'd0));
        checkOutput("ch1", FW'(features_top[FW-CW-1 -: CW]), FW'(2'd1));
        checkOutput("ch213_lsb", FW'(features_top[CW-1:0]), FW'(2'd1));
        idle(3);
        fin_ready_req = 1'b1;
        idle(3);

        // Backpressure: two frames fill both buffers, third stalls at beat 0
        fin_ready_req = 1'b0;
        sendFrame(NC, NC - 1, 1'b1, 1'b0);
        sendFrame(NC, NC - 1, 1'b1, 1'b0);
        #2;
        checkOutput("bp_ready_low", FW'(s_ready), FW'(1'b0));
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, CW'($urandom), 1'b0);
        end
        fin_ready_req = 1'b1;
        sendFrame(NC, NC - 1, 1'b1, 1'b0);
        idle(4);

        // Full throughput: four frames back-to-back with fin_ready held high
        fin_ready_req = 1'b1;
        for (int f = 0; f < 4; f++) begin
            sendFrame(NC, NC - 1, 1'b0, 1'b0);
        end
        idle(3);

`ifdef FRAME_CHECK_EN
        // Early s_last on beat 100, then a clean frame
        sendFrame(101, 100, 1'b1, 1'b0);
        sendFrame(NC, NC - 1, 1'b1, 1'b0);
        idle(3);
        // Missing s_last, ten discarded beats, then a clean frame
        sendFrame(NC, -1, 1'b1, 1'b0);
        sendFrame(10, 9, 1'b1, 1'b0);
        sendFrame(NC, NC - 1, 1'b1, 1'b0);
        idle(3);
`else
        // s_last mid-frame is ignored; frame completes on count
        sendFrame(NC, 100, 1'b1, 1'b0);
        idle(3);
`endif

        // Mid-frame reset with one completed frame pending
        fin_ready_req = 1'b0;
        sendFrame(NC, NC - 1, 1'b1, 1'b0);
        sendFrame(50, -1, 1'b1, 1'b0);
        rst_req = 1'b1;
        idle(3);
        rst_req       = 1'b0;
        fin_ready_req = 1'b1;
        idle(3);
        sendFrame(NC, NC - 1, 1'b1, 1'b0);
        idle(3);

        // Random downstream readiness
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            sendFrame(NC, NC - 1, 1'b1, 1'b0);
        end
        idle(10);
        rand_ready = 1'b0;
        idle(5);

        $display("[TB] ran %0d cycles", cycles);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/feature_frame_assembler.md
# feature_frame_assembler

Front-end stage ahead of the sensor fusion pipeline's hypervector generator. It accepts one `CHANNEL_WIDTH` feature per cycle from a serial sensor stream, with an end-of-frame marker, and assembles `NUM_CHANNEL` features into a full frame. It then presents the frame on the fusion top's `fin_valid` / `fin_ready` / `features_top` handshake. A ping-pong buffer pair lets the next frame fill while the previous one waits for the downstream stage.

## Interface
Parameters:
- `NUM_CHANNEL`, default `` `TOTAL_NUM_CHANNEL `` (214): features per frame.
- `CHANNEL_WIDTH`, default `` `CHANNEL_WIDTH `` (2): bits per feature.

Ports:
- `clk`  input  1  single clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `s_valid`  input  1  serial feature beat valid.
- `s_ready`  output  1  beat accepted when `s_valid && s_ready`.
- `s_feature`  input  `CHANNEL_WIDTH`  feature for the current channel index.
- `s_last`  input  1  marks the final beat of a frame.
- `fin_valid`  output  1  assembled frame available.
- `fin_ready`  input  1  downstream accepts the frame.
- `features_top`  output  `NUM_CHANNEL*CHANNEL_WIDTH`  assembled frame.
- `frame_err`  output  1  one-cycle pulse on a framing violation.

## Operation
- Beat k of a frame (k = 0..`NUM_CHANNEL`-1) is written to bits `[(NUM_CHANNEL-k)*CHANNEL_WIDTH-1 -: CHANNEL_WIDTH]`. Channel 0 sits at the MSBs, channel `NUM_CHANNEL`-1 at bits `[CHANNEL_WIDTH-1:0]`.
- Storage is two frame buffers.
  - `wr_sel` selects the buffer being filled; `rd_sel` selects the buffer driving `features_top`.
  - `occ` (0..2) counts completed frames not yet taken.
- Write index `wr_idx` has width `` `ceilLog2(NUM_CHANNEL) ``.
  - It increments per accepted beat and returns to 0 after beat `NUM_CHANNEL`-1.
  - On that final beat the frame completes: `occ` += 1 and `wr_sel` toggles.
- A frame handshake (`fin_valid && fin_ready`) does `occ` -= 1 and toggles `rd_sel`. Frame completion and frame handshake in the same cycle leave `occ` unchanged and toggle both selects.
- `fin_valid` = (`occ` != 0).
- `features_top` holds stable while `fin_valid && !fin_ready`.
- State machine (`FILL`, `DISCARD`):
  - `FILL`: normal assembly.
  - `DISCARD`: accepted beats are dropped; the machine returns to `FILL` after accepting a beat with `s_last`=1, and `wr_idx` = 0 on return.
- Reset values: `s_ready`=0, `fin_valid`=0, `frame_err`=0, `occ`=0, `wr_idx`=0, `wr_sel`=`rd_sel`=0, state `FILL`. Buffer contents are not reset.

## Timing
- Last beat of a frame accepted in cycle N: `fin_valid` is 1 in cycle N+1.
- `s_ready` is registered.
  - It becomes 1 in the first cycle after `rst` deasserts.
  - It goes 0 in the cycle after the frame completion that makes `occ`=2, unless a frame handshake occurs in that same cycle.
  - It returns to 1 in the cycle after the handshake that frees a buffer.
- With `fin_ready` held 1, throughput is one beat per cycle with no bubble between frames. `fin_valid` is high for one cycle per `NUM_CHANNEL` beats.
- `frame_err` pulses in the cycle after the offending beat is accepted.
- `rst` mid-frame discards the partial frame and both stored frames. No `fin_valid` is produced for them.

## Configuration
- `FRAME_CHECK_EN` defined (framing check on):
  - `s_last`=1 on a beat with `wr_idx` < `NUM_CHANNEL`-1: pulse `frame_err`, drop the partial frame, set `wr_idx` = 0, stay in `FILL`.
  - Beat `NUM_CHANNEL`-1 with `s_last`=0: pulse `frame_err`, drop the frame (no `occ` change), enter `DISCARD`.
- `FRAME_CHECK_EN` undefined (framing check off):
  - `s_last` is ignored and frames complete purely on count.
  - `frame_err` is tied 0 and `DISCARD` is unreachable.

## Structure
- The shared package/header provides:
  - `TOTAL_NUM_CHANNEL`, `CHANNEL_WIDTH`, the `ceilLog2` macro;
  - a channel-index width constant;
  - the state enum typedef (`FILL`, `DISCARD`).
- One sub-module is natural: `frame_pingpong_buffer`.
  - Ports: two `NUM_CHANNEL*CHANNEL_WIDTH` registers, a beat write port (`wr_sel`, `wr_idx`, data, enable), and read mux `rd_sel`.
  - Handshake, FSM and occupancy control live in the top.

## Test plan
- **Single frame:** reset, then 214 beats with `s_feature` = k mod 4 and `s_last` on beat 213 → `fin_valid` the cycle after beat 213; `features_top[427:426]`=0, `[425:424]`=1, `[1:0]`=1 (213 mod 4).
- **Backpressure:** `fin_ready`=0, three frames offered back-to-back → two frames accepted. `s_ready`=0 after the second frame's last beat; the third frame stalls at beat 0 until `fin_ready`=1, then completes. Frames are delivered in order with contents intact.
- **Full throughput:** `fin_ready`=1, four frames streamed continuously → `s_ready` never drops after reset; `fin_valid` is a single-cycle pulse every 214 cycles.
- **Early `s_last`** (`FRAME_CHECK_EN`): `s_last` on beat 100 → `frame_err` pulse, no `fin_valid`. The following 214-beat frame is delivered correctly.
- **Missing `s_last`** (`FRAME_CHECK_EN`): beat 213 without `s_last`, then 10 beats ending in `s_last` → `frame_err` at beat 213, no `fin_valid`, the 10 beats are discarded. The next frame is delivered correctly.
- **Mid-frame reset:** `rst` after 50 beats, with one completed frame pending → `fin_valid`=0 and `s_ready`=0 during reset. No stale frame is delivered; the next full frame is correct.
